// File: rtl/regfile_mp_pkg.sv
// Shared defaults and index types for the multi-ported register file.
// The AW helper keeps every file deriving address width the same way.
package regfile_mp_pkg;

    localparam int unsigned NUM_REGS_DEF = 64;
    localparam int unsigned DATA_W_DEF   = 64;
    localparam int unsigned NUM_RD_DEF   = 4;
    localparam int unsigned NUM_WR_DEF   = 2;
    localparam int unsigned NUM_INV_DEF  = 2;

    function automatic int unsigned aw_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned AW_DEF = aw_of(NUM_REGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp.
// The master side is commit/rename/issue; the slave side is the register file.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned NUM_WR   = NUM_WR_DEF,
    parameter int unsigned NUM_INV  = NUM_INV_DEF
);
    localparam int unsigned AW = aw_of(NUM_REGS);

    logic [NUM_WR-1:0]              wr_en;
    logic [NUM_WR-1:0][AW-1:0]      wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
    logic [NUM_INV-1:0]             inv_en;
    logic [NUM_INV-1:0][AW-1:0]     inv_addr;
    logic                           flush;
    logic                           rd_req;
    logic [NUM_RD-1:0][AW-1:0]      rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]              rd_valid;
    logic                           rd_done;

    modport master (
        output wr_en, wr_addr, wr_data, inv_en, inv_addr, flush, rd_req, rd_addr,
        input  rd_data, rd_valid, rd_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, inv_en, inv_addr, flush, rd_req, rd_addr,
        output rd_data, rd_valid, rd_done
    );

endinterface

// File: rtl/regfile_mp_nextstate.sv
// Per-register next data/valid: highest write port wins, invalidate beats write valid,
// flush beats invalidate. Register 0 is pinned to data 0 / valid 1.
module regfile_mp_nextstate
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_WR   = NUM_WR_DEF,
    parameter int unsigned NUM_INV  = NUM_INV_DEF,
    localparam int unsigned AW      = aw_of(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] i_data,
    input  logic [NUM_REGS-1:0]             i_valid,
    input  logic [NUM_WR-1:0]               i_wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]       i_wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]   i_wr_data,
    input  logic [NUM_INV-1:0]              i_inv_en,
    input  logic [NUM_INV-1:0][AW-1:0]      i_inv_addr,
    input  logic                            i_flush,
    output logic [NUM_REGS-1:0][DATA_W-1:0] o_data,
    output logic [NUM_REGS-1:0]             o_valid
);

    always_comb begin
        o_data  = i_data;
        o_valid = i_valid;
        for (int r = 1; r < NUM_REGS; r++) begin
            // Ascending scan so the highest-index matching port is the last to assign.
            for (int i = 0; i < NUM_WR; i++) begin
                if (i_wr_en[i] && (i_wr_addr[i] == AW'(r))) begin
                    o_data[r]  = i_wr_data[i];
                    o_valid[r] = 1'b1;
                end
            end
            if (i_flush) begin
                o_valid[r] = 1'b1;
            end else begin
                for (int j = 0; j < NUM_INV; j++) begin
                    if (i_inv_en[j] && (i_inv_addr[j] == AW'(r))) begin
                        o_valid[r] = 1'b0;
                    end
                end
            end
        end
        o_data[0]  = '0;
        o_valid[0] = 1'b1;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register valid bits and one-cycle registered reads.
// Reads sample the post-edge state, so same-cycle writes/invalidates/flush are visible.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter int unsigned NUM_WR   = NUM_WR_DEF,
    parameter int unsigned NUM_INV  = NUM_INV_DEF
) (
    input logic         clk,
    input logic         res_n,
    regfile_mp_if.slave bus
);

    logic [NUM_REGS-1:0][DATA_W-1:0] r_data;
    logic [NUM_REGS-1:0]             r_valid;
    logic [NUM_REGS-1:0][DATA_W-1:0] w_data_nxt;
    logic [NUM_REGS-1:0]             w_valid_nxt;
    logic [NUM_RD-1:0][DATA_W-1:0]   r_rd_data;
    logic [NUM_RD-1:0]               r_rd_valid;
    logic                            r_rd_done;

    regfile_mp_nextstate #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .NUM_WR   (NUM_WR),
        .NUM_INV  (NUM_INV)
    ) u_nextstate (
        .i_data     (r_data),
        .i_valid    (r_valid),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_wr_data  (bus.wr_data),
        .i_inv_en   (bus.inv_en),
        .i_inv_addr (bus.inv_addr),
        .i_flush    (bus.flush),
        .o_data     (w_data_nxt),
        .o_valid    (w_valid_nxt)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_data  <= '0;
            r_valid <= NUM_REGS'(1);
        end else begin
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Read from the next-state view so the response matches storage after this edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            r_rd_done  <= 1'b0;
        end else begin
            r_rd_done <= bus.rd_req;
            if (bus.rd_req) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    r_rd_data[p]  <= w_data_nxt[bus.rd_addr[p]];
                    r_rd_valid[p] <= w_valid_nxt[bus.rd_addr[p]];
                end
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_done  = r_rd_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// compared against an array-based model of the architectural register state.
module tb_regfile_mp;
    import regfile_mp_pkg::*;

    localparam int unsigned NR   = NUM_REGS_DEF;
    localparam int unsigned DW   = DATA_W_DEF;
    localparam int unsigned NRD  = NUM_RD_DEF;
    localparam int unsigned NWR  = NUM_WR_DEF;
    localparam int unsigned NINV = NUM_INV_DEF;
    localparam int unsigned AW   = aw_of(NR);

    logic clk = 1'b0;
    logic res_n;

    regfile_mp_if #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .NUM_RD   (NRD),
        .NUM_WR   (NWR),
        .NUM_INV  (NINV)
    ) bus ();

    regfile_mp #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .NUM_RD   (NRD),
        .NUM_WR   (NWR),
        .NUM_INV  (NINV)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [DW-1:0] m_data [NR];
    logic          m_valid [NR];
    logic [DW-1:0] exp_rd_data [NRD];
    logic          exp_rd_valid [NRD];
    logic          exp_done;

    int    n_checks = 0;
    int    n_errors = 0;
    string step;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s/%s got=%h exp=%h", step, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_data[r]  = '0;
            m_valid[r] = (r == 0);
        end
        for (int p = 0; p < NRD; p++) begin
            exp_rd_data[p]  = '0;
            exp_rd_valid[p] = 1'b0;
        end
        exp_done = 1'b0;
    endtask

    // Architectural effect of one clock edge, computed from the sampled inputs.
    task automatic model_edge();
        int a;
        for (int i = 0; i < NWR; i++) begin
            a = int'(bus.wr_addr[i]);
            if (bus.wr_en[i] && a != 0) begin
                m_data[a]  = bus.wr_data[i];
                m_valid[a] = 1'b1;
            end
        end
        if (bus.flush) begin
            for (int r = 0; r < NR; r++) m_valid[r] = 1'b1;
        end else begin
            for (int j = 0; j < NINV; j++) begin
                a = int'(bus.inv_addr[j]);
                if (bus.inv_en[j] && a != 0) m_valid[a] = 1'b0;
            end
        end
        exp_done = bus.rd_req;
        if (bus.rd_req) begin
            for (int p = 0; p < NRD; p++) begin
                exp_rd_data[p]  = m_data[int'(bus.rd_addr[p])];
                exp_rd_valid[p] = m_valid[int'(bus.rd_addr[p])];
            end
        end
    endtask

    task automatic check_outputs();
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("rd_data%0d", p), bus.rd_data[p], exp_rd_data[p]);
            chk($sformatf("rd_valid%0d", p), DW'(bus.rd_valid[p]), DW'(exp_rd_valid[p]));
        end
        chk("rd_done", DW'(bus.rd_done), DW'(exp_done));
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.inv_en   = '0;
        bus.inv_addr = '0;
        bus.flush    = 1'b0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
    endtask

    // Inputs are set at the negedge before calling; returns at the following negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
        idle();
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NWR; i++) begin
            bus.wr_en[i]   = 1'($urandom_range(0, 1));
            bus.wr_addr[i] = AW'($urandom_range(0, 15));
            bus.wr_data[i] = DW'({$urandom, $urandom});
        end
        for (int j = 0; j < NINV; j++) begin
            bus.inv_en[j]   = ($urandom_range(0, 2) == 0);
            bus.inv_addr[j] = AW'($urandom_range(0, 15));
        end
        bus.flush  = ($urandom_range(0, 15) == 0);
        bus.rd_req = ($urandom_range(0, 3) != 0);
        for (int p = 0; p < NRD; p++) begin
            bus.rd_addr[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1))
                                                         : AW'($urandom_range(0, 15));
        end
    endtask

    initial begin
        step  = "reset";
        res_n = 1'b1;
        idle();
        #2 res_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;

        step = "reset_sweep";
        for (int a = 0; a < NR; a++) begin
            bus.rd_req = 1'b1;
            for (int p = 0; p < NRD; p++) bus.rd_addr[p] = AW'((a + p * 17) % NR);
            cycle();
        end
        step = "hold";
        cycle();

        step = "write_bypass";
        bus.wr_en[0]   = 1'b1;
        bus.wr_addr[0] = AW'(5);
        bus.wr_data[0] = DW'(64'hDEAD_BEEF);
        bus.rd_req     = 1'b1;
        bus.rd_addr[0] = AW'(5);
        cycle();
        chk("r5_data", bus.rd_data[0], DW'(64'hDEAD_BEEF));
        chk("r5_valid", DW'(bus.rd_valid[0]), DW'(1));

        step = "ww_conflict";
        bus.wr_en      = '1;
        bus.wr_addr[0] = AW'(7);
        bus.wr_data[0] = DW'(1);
        bus.wr_addr[1] = AW'(7);
        bus.wr_data[1] = DW'(2);
        cycle();
        bus.rd_req     = 1'b1;
        bus.rd_addr[2] = AW'(7);
        cycle();
        chk("r7_data", bus.rd_data[2], DW'(2));
        chk("r7_valid", DW'(bus.rd_valid[2]), DW'(1));

        step = "inv_vs_write";
        bus.inv_en[0]   = 1'b1;
        bus.inv_addr[0] = AW'(9);
        bus.wr_en[0]    = 1'b1;
        bus.wr_addr[0]  = AW'(9);
        bus.wr_data[0]  = DW'(64'h55);
        cycle();
        bus.rd_req     = 1'b1;
        bus.rd_addr[1] = AW'(9);
        cycle();
        chk("r9_data", bus.rd_data[1], DW'(64'h55));
        chk("r9_valid", DW'(bus.rd_valid[1]), DW'(0));
        bus.wr_en[1]   = 1'b1;
        bus.wr_addr[1] = AW'(9);
        bus.wr_data[1] = DW'(64'h66);
        bus.rd_req     = 1'b1;
        bus.rd_addr[1] = AW'(9);
        cycle();
        chk("r9_data2", bus.rd_data[1], DW'(64'h66));
        chk("r9_valid2", DW'(bus.rd_valid[1]), DW'(1));

        step = "r0_and_flush";
        bus.wr_en       = '1;
        bus.wr_addr[0]  = AW'(3);
        bus.wr_data[0]  = DW'(64'h33);
        bus.wr_addr[1]  = AW'(4);
        bus.wr_data[1]  = DW'(64'h44);
        cycle();
        bus.inv_en      = '1;
        bus.inv_addr[0] = AW'(3);
        bus.inv_addr[1] = AW'(4);
        cycle();
        bus.wr_en[0]    = 1'b1;
        bus.wr_addr[0]  = AW'(0);
        bus.wr_data[0]  = DW'(64'hFF);
        bus.inv_en[0]   = 1'b1;
        bus.inv_addr[0] = AW'(0);
        bus.rd_req      = 1'b1;
        bus.rd_addr[0]  = AW'(0);
        bus.rd_addr[1]  = AW'(3);
        bus.rd_addr[2]  = AW'(4);
        cycle();
        chk("r0_data", bus.rd_data[0], DW'(0));
        chk("r0_valid", DW'(bus.rd_valid[0]), DW'(1));
        chk("r3_inv", DW'(bus.rd_valid[1]), DW'(0));
        chk("r4_inv", DW'(bus.rd_valid[2]), DW'(0));
        bus.flush       = 1'b1;
        bus.inv_en[0]   = 1'b1;
        bus.inv_addr[0] = AW'(5);
        bus.rd_req      = 1'b1;
        bus.rd_addr[0]  = AW'(0);
        bus.rd_addr[1]  = AW'(3);
        bus.rd_addr[2]  = AW'(4);
        bus.rd_addr[3]  = AW'(5);
        cycle();
        chk("flush_r0", DW'(bus.rd_valid[0]), DW'(1));
        chk("flush_r3", DW'(bus.rd_valid[1]), DW'(1));
        chk("flush_r4", DW'(bus.rd_valid[2]), DW'(1));
        chk("flush_beats_inv", DW'(bus.rd_valid[3]), DW'(1));
        chk("flush_r3_data", bus.rd_data[1], DW'(64'h33));

        step = "random";
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle();
        end

        step = "stream_reset";
        for (int k = 0; k < 3; k++) begin
            bus.rd_req = 1'b1;
            for (int p = 0; p < NRD; p++) bus.rd_addr[p] = AW'($urandom_range(0, 15));
            cycle();
            chk($sformatf("stream_done%0d", k), DW'(bus.rd_done), DW'(1));
        end
        bus.rd_req = 1'b1;
        #2 res_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        res_n = 1'b1;
        idle();
        cycle();
        chk("no_done_after_release", DW'(bus.rd_done), DW'(0));

        step = "first_edge";
        #2 res_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        res_n          = 1'b1;
        bus.wr_en[1]   = 1'b1;
        bus.wr_addr[1] = AW'(12);
        bus.wr_data[1] = DW'(64'hABC);
        bus.rd_req     = 1'b1;
        bus.rd_addr[3] = AW'(12);
        cycle();
        chk("first_done", DW'(bus.rd_done), DW'(1));
        chk("first_data", bus.rd_data[3], DW'(64'hABC));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter NUM_REGS, default 64: number of architectural registers; power of two, at least 2.
REQ-002 Parameter DATA_W, default 64: register width in bits.
REQ-003 Parameter NUM_RD, default 4: number of read ports.
REQ-004 Parameter NUM_WR, default 2: number of write ports.
REQ-005 Parameter NUM_INV, default 2: number of invalidate ports; AW = clog2(NUM_REGS).
REQ-006 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock, all state changes on rising edge.
  res_n  in  1  asynchronous active-low reset.
  wr_en  in  NUM_WR  per-port write enable, from commit.
  wr_addr  in  NUM_WR*AW  per-port write address.
  wr_data  in  NUM_WR*DATA_W  per-port write data.
  inv_en  in  NUM_INV  per-port invalidate (destination allocated), from rename.
  inv_addr  in  NUM_INV*AW  per-port invalidate address.
  flush  in  1  mark every register valid (pipeline flush).
  rd_req  in  1  one-cycle read request, samples all rd_addr.
  rd_addr  in  NUM_RD*AW  per-port read address.
  rd_data  out  NUM_RD*DATA_W  registered read data.
  rd_valid  out  NUM_RD  registered valid bit per read port.
  rd_done  out  1  one-cycle pulse, read response valid.

Function
REQ-007 Storage: NUM_REGS x DATA_W data array plus NUM_REGS-bit valid vector.
REQ-008 Register 0: data is constant 0 and valid is constant 1; writes, invalidates and flush to address 0 are ignored.
REQ-009 Write: wr_en[i] with a nonzero address sets data to wr_data[i] and sets valid to 1 at the next edge.
REQ-010 Write/write conflict: when several ports target the same address in one cycle, the highest-index port wins.
REQ-011 Invalidate: inv_en[j] with a nonzero address clears valid at the next edge; data is unchanged.
REQ-012 Invalidate vs write on the same address in the same cycle: data takes the write, valid ends 0.
REQ-013 Flush: flush=1 sets all valid bits to 1 at the next edge. It takes priority over invalidate and is applied together with any same-cycle writes.
REQ-014 Read latency: rd_req=1 in cycle N causes rd_data, rd_valid and rd_done=1 in cycle N+1; rd_done=0 otherwise.
REQ-015 The read response SHALL reflect the post-edge state: cycle-N writes are bypassed into rd_data, and cycle-N invalidates and flush are reflected in rd_valid.
REQ-016 rd_data and rd_valid SHALL hold their last response when rd_req=0.
REQ-017 Back-to-back rd_req on consecutive cycles SHALL produce back-to-back responses.
REQ-018 Reads, writes and invalidates are fully concurrent; there is no stall or backpressure.

Reset
REQ-019 res_n=0 asynchronously clears all data to 0, sets valid[0]=1, clears valid[1..NUM_REGS-1] to 0, and drives rd_data=0, rd_valid=0, rd_done=0.
REQ-020 A rd_req accepted in the cycle that reset asserts is dropped; no rd_done follows the release of reset.
REQ-021 The first rising edge after res_n deasserts SHALL accept rd_req, wr_en and inv_en normally.

Structure
REQ-022 Defaults for NUM_REGS/DATA_W/NUM_RD/NUM_WR/NUM_INV, the AW derivation and the register-index typedef SHALL live in the shared core package.
REQ-023 One sub-module, regfile_mp_nextstate, SHALL compute the per-register next data and next valid (write/invalidate/flush priority). Its outputs feed both the storage update and the read bypass, so both use identical priority logic.

Verification
REQ-024 Reset -> for every address a, rd_req with rd_addr=a returns data 0 and valid (a==0) after one cycle, with rd_done=1 for exactly one cycle.
REQ-025 Write r5=0xDEAD_BEEF on port 0 and rd_req of r5 in the same cycle -> next cycle rd_data=0xDEAD_BEEF, rd_valid=1.
REQ-026 Same cycle: port0 writes r7=0x1, port1 writes r7=0x2 -> subsequent read of r7 returns 0x2, valid 1.
REQ-027 inv r9 and write r9=0x55 in the same cycle -> read returns 0x55 with valid 0; a later write of 0x66 -> 0x66, valid 1.
REQ-028 Write r0=0xFF, invalidate r0, flush -> r0 reads 0 with valid 1 throughout; flush sets the valid bits of previously invalidated r3 and r4 to 1.
REQ-029 rd_req held for 3 cycles, then res_n pulsed low mid-stream -> responses in the 3 cycles following the request cycles; outputs go to 0 immediately on reset; no rd_done after release.
